// File: rtl/cai_submit_fetch.sv
// CAI submit ring consumer: fetches SUBMIT_DESC_V1 records one word at a time,
// validates header and reserved fields, and hands each record to dispatch.

package carbon_cai_pkg;
    localparam int         CARBON_CAI_SUBMIT_DESC_V1_SIZE_BYTES       = 32;
    localparam logic [7:0] CARBON_CAI_SUBMIT_DESC_V1_VERSION          = 8'h01;
    localparam int         CARBON_CAI_SUBMIT_DESC_V1_OFF_VERSION      = 0;
    localparam int         CARBON_CAI_SUBMIT_DESC_V1_OFF_SIZE_DW      = 1;
    localparam int         CARBON_CAI_SUBMIT_DESC_V1_OFF_FORMAT_FLAGS = 2;
    localparam int         CARBON_CAI_SUBMIT_DESC_V1_OFF_RESERVED2    = 30;
endpackage

module cai_submit_fetch
    import carbon_cai_pkg::*;
#(
    parameter int DESC_BYTES = CARBON_CAI_SUBMIT_DESC_V1_SIZE_BYTES,
    parameter int IDX_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_enable,
    input  logic [63:0]             cfg_ring_base,
    input  logic [IDX_W-1:0]        cfg_ring_entries,
    input  logic [IDX_W-1:0]        cfg_submit_tail,
    input  logic                    submit_doorbell,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [63:0]             mem_req_addr,
    input  logic                    mem_rsp_valid,
    input  logic [31:0]             mem_rsp_data,
    input  logic                    mem_rsp_err,
    output logic                    desc_valid,
    input  logic                    desc_ready,
    output logic [DESC_BYTES*8-1:0] desc_data,
    output logic [IDX_W-1:0]        desc_index,
    output logic [1:0]              desc_status,
    output logic [IDX_W-1:0]        head_idx,
    output logic                    cfg_err,
    output logic                    busy
);

    localparam int                WORDS     = DESC_BYTES / 4;
    localparam int                WCNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [IDX_W-1:0]        head_r;
    logic [IDX_W-1:0]        tail_r;
    logic [IDX_W-1:0]        head_inc_s;
    logic [IDX_W-1:0]        desc_index_r;
    logic [WCNT_W-1:0]       wcnt_r;
    logic [63:0]             addr_r;
    logic [DESC_BYTES*8-1:0] desc_buf_r;
    logic [1:0]              desc_status_r;
    logic                    ferr_r;
    logic                    cfg_err_r;
    logic                    mem_req_valid_r;
    logic                    desc_valid_r;
    logic                    busy_r;
    logic                    start_s;
    logic                    rsp_take_s;
    logic                    desc_take_s;
    logic                    last_word_s;

    // Header and reserved-field validation of an assembled record.
    function automatic logic is_malformed(input logic [DESC_BYTES*8-1:0] d);
        logic [7:0]  version;
        logic [7:0]  size_dw;
        logic [15:0] flags;
        logic [15:0] rsvd;
        version = d[CARBON_CAI_SUBMIT_DESC_V1_OFF_VERSION*8 +: 8];
        size_dw = d[CARBON_CAI_SUBMIT_DESC_V1_OFF_SIZE_DW*8 +: 8];
        flags   = d[CARBON_CAI_SUBMIT_DESC_V1_OFF_FORMAT_FLAGS*8 +: 16];
        rsvd    = d[CARBON_CAI_SUBMIT_DESC_V1_OFF_RESERVED2*8 +: 16];
        is_malformed = (version != CARBON_CAI_SUBMIT_DESC_V1_VERSION) ||
                       (size_dw != 8'(WORDS)) ||
                       (flags != 16'h0000) ||
                       (rsvd != 16'h0000);
    endfunction

    // Next-state and transfer strobes.
    always_comb begin
        state_s     = state_r;
        start_s     = 1'b0;
        rsp_take_s  = 1'b0;
        desc_take_s = 1'b0;
        last_word_s = (wcnt_r == WCNT_LAST);
        head_inc_s  = ((head_r + IDX_W'(1)) == cfg_ring_entries) ? {IDX_W{1'b0}}
                                                                 : (head_r + IDX_W'(1));
        case (state_r)
            ST_IDLE: begin
                if (cfg_enable && (cfg_ring_entries != {IDX_W{1'b0}}) && (head_r != tail_r)) begin
                    state_s = ST_REQ;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_take_s = 1'b1;
                    state_s    = last_word_s ? ST_CHECK : ST_REQ;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_CHECK: begin
                state_s = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (desc_ready) begin
                    desc_take_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_PRESENT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and handshake outputs, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            mem_req_valid_r <= 1'b0;
            desc_valid_r    <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            mem_req_valid_r <= (state_s == ST_REQ);
            desc_valid_r    <= (state_s == ST_PRESENT);
            busy_r          <= (state_s != ST_IDLE);
        end
    end

    // Producer index capture; an out-of-range tail is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_r    <= {IDX_W{1'b0}};
            cfg_err_r <= 1'b0;
        end else if (submit_doorbell) begin
            if (cfg_submit_tail < cfg_ring_entries) begin
                tail_r <= cfg_submit_tail;
            end else begin
                cfg_err_r <= 1'b1;
            end
        end
    end

    // Fetch datapath: word address, record assembly, status and head advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r        <= 64'd0;
            wcnt_r        <= {WCNT_W{1'b0}};
            desc_buf_r    <= {(DESC_BYTES*8){1'b0}};
            ferr_r        <= 1'b0;
            desc_index_r  <= {IDX_W{1'b0}};
            desc_status_r <= 2'd0;
            head_r        <= {IDX_W{1'b0}};
        end else begin
            if (start_s) begin
                addr_r <= cfg_ring_base + ({{(64-IDX_W){1'b0}}, head_r} * 64'(DESC_BYTES));
                wcnt_r <= {WCNT_W{1'b0}};
            end else if (rsp_take_s && !last_word_s) begin
                addr_r <= addr_r + 64'd4;
                wcnt_r <= wcnt_r + WCNT_W'(1);
            end
            if (rsp_take_s) begin
                desc_buf_r[{wcnt_r, 5'b00000} +: 32] <= mem_rsp_data;
                ferr_r <= ferr_r | mem_rsp_err;
            end else if (desc_take_s) begin
                ferr_r <= 1'b0;
            end
            // Bus errors outrank validation: a partially bad record cannot be trusted.
            if (state_r == ST_CHECK) begin
                desc_index_r  <= head_r;
                desc_status_r <= ferr_r ? 2'd2 : (is_malformed(desc_buf_r) ? 2'd1 : 2'd0);
            end
            if (desc_take_s) begin
                head_r <= head_inc_s;
            end
        end
    end

    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = addr_r;
    assign desc_valid    = desc_valid_r;
    assign desc_data     = desc_buf_r;
    assign desc_index    = desc_index_r;
    assign desc_status   = desc_status_r;
    assign head_idx      = head_r;
    assign cfg_err       = cfg_err_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_cai_submit_fetch.sv
// Directed bench for cai_submit_fetch: ring memory model, expected-descriptor
// scoreboard built from ring contents, and per-cycle handshake checks.

module tb_cai_submit_fetch;
    import carbon_cai_pkg::*;

    localparam int          DB      = CARBON_CAI_SUBMIT_DESC_V1_SIZE_BYTES;
    localparam int          W       = DB / 4;
    localparam int          ENTRIES = 4;
    localparam int          MEMW    = (ENTRIES + 1) * W;
    localparam int          CW      = (DB * 8 > 64) ? DB * 8 : 64;
    localparam logic [63:0] BASE    = 64'h1000;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_enable;
    logic [63:0]     cfg_ring_base;
    logic [15:0]     cfg_ring_entries;
    logic [15:0]     cfg_submit_tail;
    logic            submit_doorbell;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [63:0]     mem_req_addr;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_data;
    logic            mem_rsp_err;
    logic            desc_valid;
    logic            desc_ready;
    logic [DB*8-1:0] desc_data;
    logic [15:0]     desc_index;
    logic [1:0]      desc_status;
    logic [15:0]     head_idx;
    logic            cfg_err;
    logic            busy;

    cai_submit_fetch #(.DESC_BYTES(DB), .IDX_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_ring_base(cfg_ring_base),
        .cfg_ring_entries(cfg_ring_entries), .cfg_submit_tail(cfg_submit_tail),
        .submit_doorbell(submit_doorbell), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
        .desc_index(desc_index), .desc_status(desc_status), .head_idx(head_idx),
        .cfg_err(cfg_err), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [DB*8-1:0] data;
        logic [15:0]     idx;
        logic [1:0]      st;
    } exp_desc_t;

    logic [31:0] mem_words [0:MEMW-1];
    bit          err_words [0:MEMW-1];
    logic [63:0] exp_addr_q [$];
    exp_desc_t   exp_desc_q [$];
    logic [63:0] acc_log [$];
    logic [15:0] idx_log [$];
    logic [1:0]  st_log  [$];
    int          model_head;
    int          req_hold;
    int          desc_hold;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Expected status straight from the record's field rules.
    function automatic logic [1:0] model_status(input logic [DB*8-1:0] img, input bit ferr);
        if (ferr) return 2'd2;
        if (img[CARBON_CAI_SUBMIT_DESC_V1_OFF_VERSION*8 +: 8] != CARBON_CAI_SUBMIT_DESC_V1_VERSION) return 2'd1;
        if (img[CARBON_CAI_SUBMIT_DESC_V1_OFF_SIZE_DW*8 +: 8] != 8'(W)) return 2'd1;
        if (img[CARBON_CAI_SUBMIT_DESC_V1_OFF_FORMAT_FLAGS*8 +: 16] != 16'h0000) return 2'd1;
        if (img[CARBON_CAI_SUBMIT_DESC_V1_OFF_RESERVED2*8 +: 16] != 16'h0000) return 2'd1;
        return 2'd0;
    endfunction

    task automatic write_desc(input int s, input logic [15:0] flags, input logic [15:0] res2);
        logic [DB*8-1:0] img;
        for (int b = 0; b < DB; b++) img[b*8 +: 8] = 8'(s * 37 + b * 5 + 3);
        img[CARBON_CAI_SUBMIT_DESC_V1_OFF_VERSION*8 +: 8]       = CARBON_CAI_SUBMIT_DESC_V1_VERSION;
        img[CARBON_CAI_SUBMIT_DESC_V1_OFF_SIZE_DW*8 +: 8]       = 8'(W);
        img[CARBON_CAI_SUBMIT_DESC_V1_OFF_FORMAT_FLAGS*8 +: 16] = flags;
        img[CARBON_CAI_SUBMIT_DESC_V1_OFF_RESERVED2*8 +: 16]    = res2;
        for (int k = 0; k < W; k++) begin
            mem_words[s*W + k] = img[k*32 +: 32];
            err_words[s*W + k] = 1'b0;
        end
    endtask

    task automatic push_slot(input int s);
        logic [DB*8-1:0] img;
        bit              ferr;
        exp_desc_t       e;
        ferr = 1'b0;
        for (int k = 0; k < W; k++) begin
            exp_addr_q.push_back(BASE + 64'(s * DB + 4 * k));
            img[k*32 +: 32] = mem_words[s*W + k];
            if (err_words[s*W + k]) ferr = 1'b1;
        end
        e.data = img;
        e.idx  = 16'(s);
        e.st   = model_status(img, ferr);
        exp_desc_q.push_back(e);
    endtask

    task automatic ring_doorbell(input int tail);
        @(negedge clk);
        cfg_submit_tail = 16'(tail);
        submit_doorbell = 1'b1;
        if (tail < ENTRIES) begin
            while (model_head != tail) begin
                push_slot(model_head);
                model_head = (model_head + 1) % ENTRIES;
            end
        end
        @(negedge clk);
        submit_doorbell = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_desc_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < budget), 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, mem_req_valid, 1'b0);
        check({tag, "_req_addr"}, mem_req_addr, 64'd0);
        check({tag, "_desc_valid"}, desc_valid, 1'b0);
        check({tag, "_desc_data"}, desc_data, '0);
        check({tag, "_desc_index"}, desc_index, 16'd0);
        check({tag, "_desc_status"}, desc_status, 2'd0);
        check({tag, "_head"}, head_idx, 16'd0);
        check({tag, "_cfg_err"}, cfg_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // Memory responder, dispatch sink and per-cycle comparisons (all on negedge).
    bit              acc_pend;
    logic [63:0]     acc_addr;
    bit              req_wait_prev;
    logic [63:0]     req_addr_prev;
    bit              desc_wait_prev;
    logic [DB*8-1:0] held_data;
    logic [15:0]     held_idx;
    logic [1:0]      held_st;

    initial begin
        acc_pend = 1'b0; req_wait_prev = 1'b0; desc_wait_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_pend = 1'b0; req_wait_prev = 1'b0; desc_wait_prev = 1'b0;
                mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = 32'd0;
            end else begin
                mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = 32'd0;
                if (acc_pend) begin
                    int widx;
                    widx = int'((acc_addr - BASE) >> 2);
                    mem_rsp_valid = 1'b1;
                    if (acc_addr >= BASE && widx < MEMW) begin
                        mem_rsp_data = mem_words[widx];
                        mem_rsp_err  = err_words[widx];
                    end
                    acc_pend = 1'b0;
                end
                if (req_wait_prev) begin
                    check("req_hold_valid", mem_req_valid, 1'b1);
                    check("req_hold_addr", mem_req_addr, req_addr_prev);
                end
                req_wait_prev = 1'b0;
                mem_req_ready = 1'b1;
                if (mem_req_valid) begin
                    if (req_hold > 0) begin
                        mem_req_ready = 1'b0;
                        req_hold--;
                        req_wait_prev = 1'b1;
                        req_addr_prev = mem_req_addr;
                    end else begin
                        acc_log.push_back(mem_req_addr);
                        if (exp_addr_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_req: got %0h required none", mem_req_addr);
                        end else begin
                            check("req_addr", mem_req_addr, exp_addr_q.pop_front());
                        end
                        acc_pend = 1'b1;
                        acc_addr = mem_req_addr;
                    end
                end
                if (desc_wait_prev) begin
                    check("desc_hold_valid", desc_valid, 1'b1);
                    check("desc_hold_data", desc_data, held_data);
                    check("desc_hold_index", desc_index, held_idx);
                    check("desc_hold_status", desc_status, held_st);
                end
                desc_wait_prev = 1'b0;
                desc_ready = 1'b1;
                if (desc_valid) begin
                    if (desc_hold > 0) begin
                        desc_ready = 1'b0;
                        desc_hold--;
                        desc_wait_prev = 1'b1;
                        held_data = desc_data; held_idx = desc_index; held_st = desc_status;
                    end else begin
                        idx_log.push_back(desc_index);
                        st_log.push_back(desc_status);
                        if (exp_desc_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_desc: got index %0h required none", desc_index);
                        end else begin
                            exp_desc_t e;
                            e = exp_desc_q.pop_front();
                            check("desc_data", desc_data, e.data);
                            check("desc_index", desc_index, e.idx);
                            check("desc_status", desc_status, e.st);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int  n0;
        int  n;
        bit  seen;
        rst = 1'b1; cfg_enable = 1'b0; cfg_ring_base = 64'd0; cfg_ring_entries = 16'd0;
        cfg_submit_tail = 16'd0; submit_doorbell = 1'b0; mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; mem_rsp_err = 1'b0; desc_ready = 1'b1;
        req_hold = 0; desc_hold = 0; model_head = 0;
        for (int i = 0; i < MEMW; i++) begin mem_words[i] = 32'd0; err_words[i] = 1'b0; end
        for (int s = 0; s < ENTRIES; s++) write_desc(s, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        cfg_ring_base = BASE; cfg_ring_entries = 16'(ENTRIES); cfg_enable = 1'b1;

        // 1: two descriptors from slot 0
        ring_doorbell(2);
        drain("t1_drain", 200);
        check("t1_head", head_idx, 16'd2);
        check("t1_idx0", idx_log[0], 16'd0);
        check("t1_idx1", idx_log[1], 16'd1);
        check("t1_first_addr", acc_log[0], 64'h1000);
        check("t1_second_addr", acc_log[W], 64'h1020);
        check("t1_status", st_log[1], 2'd0);

        // 2: move head to 3, then wrap through slot 0
        ring_doorbell(3);
        drain("t2a_drain", 200);
        ring_doorbell(1);
        drain("t2b_drain", 200);
        check("t2_head", head_idx, 16'd1);
        check("t2_idx_wrap3", idx_log[3], 16'd3);
        check("t2_idx_wrap0", idx_log[4], 16'd0);
        seen = 1'b0;
        foreach (acc_log[i]) if (acc_log[i] == 64'h1080) seen = 1'b1;
        check("t2_no_slot4_read", seen, 1'b0);

        // 3: malformed flags / reserved2
        write_desc(1, 16'h0001, 16'h0000);
        write_desc(2, 16'h0000, 16'hDEAD);
        ring_doorbell(3);
        drain("t3_drain", 200);
        check("t3_status_flags", st_log[5], 2'd1);
        check("t3_status_rsvd", st_log[6], 2'd1);
        check("t3_head", head_idx, 16'd3);

        // 4: bus error on word 2 of a valid record
        err_words[3*W + 2] = 1'b1;
        n0 = acc_log.size();
        ring_doorbell(0);
        drain("t4_drain", 200);
        err_words[3*W + 2] = 1'b0;
        check("t4_status", st_log[7], 2'd2);
        check("t4_reads", acc_log.size() - n0, W);
        check("t4_head", head_idx, 16'd0);

        // 5: back-pressure on both sides
        req_hold = 5; desc_hold = 3;
        n0 = acc_log.size();
        ring_doorbell(1);
        drain("t5_drain", 300);
        check("t5_reads", acc_log.size() - n0, W);
        check("t5_idx", idx_log[8], 16'd0);
        check("t5_head", head_idx, 16'd1);

        // 6: out-of-range tail
        n0 = acc_log.size();
        ring_doorbell(7);
        repeat (10) @(negedge clk);
        check("t6_cfg_err", cfg_err, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_no_reads", acc_log.size() - n0, 0);
        check("t6_head", head_idx, 16'd1);

        // 6b: reset while a read is outstanding
        n0 = acc_log.size();
        ring_doorbell(2);
        n = 0;
        while (acc_log.size() == n0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("t6b_req_seen", (n < 50), 1'b1);
        #1;
        check("t6b_wait_busy", busy, 1'b1);
        check("t6b_wait_noreq", mem_req_valid, 1'b0);
        rst = 1'b1;
        exp_addr_q.delete(); exp_desc_q.delete(); model_head = 0;
        #1;
        check_all_zero("t6b_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n0 = acc_log.size();
        repeat (6) @(negedge clk);
        check("t6b_idle_after", busy, 1'b0);
        check("t6b_head_after", head_idx, 16'd0);
        check("t6b_no_reads_after", acc_log.size() - n0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
